// File: rtl/rx_tx_frame_buffer.sv
// rtl/rx_tx_frame_buffer.sv - Rx-to-Tx frame FIFO with store-and-forward/cut-through release
//
// Purpose:
//   Buffers bytes received from the rx module (with partial-byte bit count) and offers
//   them to the tx module through the ready_to_send/req handshake. Frames with errors
//   or that overflow the FIFO are discarded; a new SOC restarts reception.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_soc, rx_eoc      1-cycle start/end-of-frame pulses from rx
//   rx_data[7:0]        received byte, LSB first
//   rx_data_bits[2:0]   valid bits in rx_data (0 = 8)
//   rx_data_valid       1-cycle pulse qualifying rx_data/rx_data_bits
//   rx_sequence_error   rx sequence error
//   rx_parity_error     rx parity error
//   tx_data[7:0]        registered copy of FIFO head byte
//   tx_data_bits[2:0]   registered copy of FIFO head bit count
//   tx_ready_to_send    head valid and released to tx
//   tx_req              1-cycle pulse, tx consumed the current byte
//   level[LW-1:0]       entries currently stored
//   overflow            1-cycle pulse, frame aborted on FIFO full
//   frame_dropped       1-cycle pulse, frame discarded (error or overflow)

module rx_tx_frame_buffer #(
    parameter int DEPTH       = 16,
    parameter int CUT_THROUGH = 0,
    parameter int LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_soc,
    input  logic          rx_eoc,
    input  logic [7:0]    rx_data,
    input  logic [2:0]    rx_data_bits,
    input  logic          rx_data_valid,
    input  logic          rx_sequence_error,
    input  logic          rx_parity_error,
    output logic [7:0]    tx_data,
    output logic [2:0]    tx_data_bits,
    output logic          tx_ready_to_send,
    input  logic          tx_req,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          frame_dropped
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [2:0]      tx_data_bits_q, tx_data_bits_d;
    logic            ready_q, ready_d;
    logic            overflow_q, overflow_d;
    logic            frame_dropped_q, frame_dropped_d;

    logic [10:0]     mem_q [DEPTH];

    logic            flush;
    logic            push;
    logic            pop;
    logic            release_ok;
    logic [10:0]     push_entry;
    logic [10:0]     head;

    // Pointers wrap modulo DEPTH so non-power-of-2 depths use every entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_entry = {rx_data_bits, rx_data};

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        overflow_d      = 1'b0;
        frame_dropped_d = 1'b0;
        flush           = 1'b0;
        push            = 1'b0;
        // ready_q already guarantees a valid head, so a req here is always a real pop.
        pop             = tx_req && ready_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_soc) begin
                    flush   = 1'b1;
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (rx_soc) begin
                    // Second SOC: restart the frame in place.
                    flush = 1'b1;
                end else if (rx_sequence_error || rx_parity_error) begin
                    flush           = 1'b1;
                    frame_dropped_d = 1'b1;
                    state_d         = ST_DROP;
                end else if (rx_data_valid && (count_q == LW'(DEPTH)) && !pop) begin
                    flush           = 1'b1;
                    overflow_d      = 1'b1;
                    frame_dropped_d = 1'b1;
                    state_d         = ST_DROP;
                end else begin
                    push = rx_data_valid;
                    if (rx_eoc) begin
                        // Level as it will be after this cycle's push/pop decides release.
                        state_d = ((count_q + LW'(rx_data_valid) - LW'(pop)) != '0)
                                  ? ST_TX : ST_IDLE;
                    end
                end
            end
            ST_TX: begin
                if (rx_soc) begin
                    flush   = 1'b1;
                    state_d = ST_RX;
                end else if (pop && (count_q == LW'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (rx_soc) begin
                    flush   = 1'b1;
                    state_d = ST_RX;
                end else if (rx_eoc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            pop      = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + LW'(push) - LW'(pop);
        end

        // Cut-through releases bytes while the frame is still open; store-and-forward
        // only once the frame has closed cleanly.
        release_ok = (state_d == ST_TX) || ((state_d == ST_RX) && (CUT_THROUGH != 0));
        ready_d    = release_ok && (count_d != '0);

        // When the byte being pushed becomes the head, memory does not hold it yet.
        if (push && ((count_q - LW'(pop)) == '0)) begin
            head = push_entry;
        end else begin
            head = mem_q[rd_ptr_d];
        end

        tx_data_d      = tx_data_q;
        tx_data_bits_d = tx_data_bits_q;
        if (ready_d) begin
            tx_data_d      = head[7:0];
            tx_data_bits_d = head[10:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tx_data_q       <= '0;
            tx_data_bits_q  <= '0;
            ready_q         <= 1'b0;
            overflow_q      <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            tx_data_q       <= tx_data_d;
            tx_data_bits_q  <= tx_data_bits_d;
            ready_q         <= ready_d;
            overflow_q      <= overflow_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    // Storage array carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_data_bits     = tx_data_bits_q;
    assign tx_ready_to_send = ready_q;
    assign level            = count_q;
    assign overflow         = overflow_q;
    assign frame_dropped    = frame_dropped_q;

endmodule

// File: tb/tb_rx_tx_frame_buffer.sv
// tb/tb_rx_tx_frame_buffer.sv - directed self-checking bench for rx_tx_frame_buffer
module tb_rx_tx_frame_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_soc = 1'b0;
    logic       rx_eoc = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [2:0] rx_data_bits = 3'd0;
    logic       rx_data_valid = 1'b0;
    logic       rx_sequence_error = 1'b0;
    logic       rx_parity_error = 1'b0;
    logic       tx_req = 1'b0;

    logic [7:0] sf_data, ct_data, d4_data;
    logic [2:0] sf_bits, ct_bits, d4_bits;
    logic       sf_rdy, ct_rdy, d4_rdy;
    logic [4:0] sf_lvl, ct_lvl;
    logic [2:0] d4_lvl;
    logic       sf_ovf, ct_ovf, d4_ovf;
    logic       sf_drp, ct_drp, d4_drp;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #37 clk = ~clk;

    rx_tx_frame_buffer #(.DEPTH(16), .CUT_THROUGH(0)) dut_sf (
        .clk(clk), .rst_n(rst_n), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
        .rx_data(rx_data), .rx_data_bits(rx_data_bits), .rx_data_valid(rx_data_valid),
        .rx_sequence_error(rx_sequence_error), .rx_parity_error(rx_parity_error),
        .tx_data(sf_data), .tx_data_bits(sf_bits), .tx_ready_to_send(sf_rdy),
        .tx_req(tx_req), .level(sf_lvl), .overflow(sf_ovf), .frame_dropped(sf_drp)
    );

    rx_tx_frame_buffer #(.DEPTH(16), .CUT_THROUGH(1)) dut_ct (
        .clk(clk), .rst_n(rst_n), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
        .rx_data(rx_data), .rx_data_bits(rx_data_bits), .rx_data_valid(rx_data_valid),
        .rx_sequence_error(rx_sequence_error), .rx_parity_error(rx_parity_error),
        .tx_data(ct_data), .tx_data_bits(ct_bits), .tx_ready_to_send(ct_rdy),
        .tx_req(tx_req), .level(ct_lvl), .overflow(ct_ovf), .frame_dropped(ct_drp)
    );

    rx_tx_frame_buffer #(.DEPTH(4), .CUT_THROUGH(0)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
        .rx_data(rx_data), .rx_data_bits(rx_data_bits), .rx_data_valid(rx_data_valid),
        .rx_sequence_error(rx_sequence_error), .rx_parity_error(rx_parity_error),
        .tx_data(d4_data), .tx_data_bits(d4_bits), .tx_ready_to_send(d4_rdy),
        .tx_req(tx_req), .level(d4_lvl), .overflow(d4_ovf), .frame_dropped(d4_drp)
    );

    // Inputs set before cyc() are sampled at its edge; outputs are read 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic soc();
        rx_soc = 1'b1;
        cyc();
        rx_soc = 1'b0;
    endtask

    task automatic eoc();
        rx_eoc = 1'b1;
        cyc();
        rx_eoc = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic [2:0] b);
        rx_data       = d;
        rx_data_bits  = b;
        rx_data_valid = 1'b1;
        cyc();
        rx_data_valid = 1'b0;
    endtask

    task automatic req();
        tx_req = 1'b1;
        cyc();
        tx_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        vec_cnt++;
        if ({sf_data, sf_bits, sf_rdy, sf_lvl, sf_ovf, sf_drp} !== 19'd0) begin
            err_cnt++;
            $display("FAIL reset_values: got data=%h bits=%0d rdy=%b lvl=%0d ovf=%b drp=%b, expected all 0",
                     sf_data, sf_bits, sf_rdy, sf_lvl, sf_ovf, sf_drp);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_store_forward();
        do_reset();
        soc();
        rx_byte(8'hA5, 3'd0);
        rx_byte(8'h3C, 3'd0);
        rx_byte(8'h0F, 3'd5);
        vec_cnt++;
        if ({sf_rdy, sf_lvl} !== {1'b0, 5'd3}) begin
            err_cnt++;
            $display("FAIL sf_before_eoc: got rdy=%b lvl=%0d, expected rdy=0 lvl=3", sf_rdy, sf_lvl);
        end
        eoc();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_bits, sf_lvl} !== {1'b1, 8'hA5, 3'd0, 5'd3}) begin
            err_cnt++;
            $display("FAIL sf_after_eoc: got rdy=%b data=%h bits=%0d lvl=%0d, expected 1 a5 0 3",
                     sf_rdy, sf_data, sf_bits, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_bits, sf_lvl} !== {1'b1, 8'h3C, 3'd0, 5'd2}) begin
            err_cnt++;
            $display("FAIL sf_pop1: got rdy=%b data=%h bits=%0d lvl=%0d, expected 1 3c 0 2",
                     sf_rdy, sf_data, sf_bits, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_bits, sf_lvl} !== {1'b1, 8'h0F, 3'd5, 5'd1}) begin
            err_cnt++;
            $display("FAIL sf_pop2: got rdy=%b data=%h bits=%0d lvl=%0d, expected 1 0f 5 1",
                     sf_rdy, sf_data, sf_bits, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL sf_pop3: got rdy=%b lvl=%0d, expected rdy=0 lvl=0", sf_rdy, sf_lvl);
        end
        // Extra req while not ready must be ignored.
        req();
        vec_cnt++;
        if ({sf_rdy, sf_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL sf_idle_req: got rdy=%b lvl=%0d, expected rdy=0 lvl=0", sf_rdy, sf_lvl);
        end
    endtask

    task automatic test_cut_through();
        do_reset();
        soc();
        rx_byte(8'h55, 3'd0);
        vec_cnt++;
        if ({ct_rdy, ct_data, ct_bits, ct_lvl} !== {1'b1, 8'h55, 3'd0, 5'd1}) begin
            err_cnt++;
            $display("FAIL ct_early_ready: got rdy=%b data=%h bits=%0d lvl=%0d, expected 1 55 0 1",
                     ct_rdy, ct_data, ct_bits, ct_lvl);
        end
        eoc();
        req();
        vec_cnt++;
        if ({ct_rdy, ct_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL ct_drained: got rdy=%b lvl=%0d, expected rdy=0 lvl=0", ct_rdy, ct_lvl);
        end
        // Back in IDLE: data without SOC is not stored.
        rx_byte(8'h77, 3'd0);
        vec_cnt++;
        if ({ct_rdy, ct_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL ct_idle_ignore: got rdy=%b lvl=%0d, expected rdy=0 lvl=0", ct_rdy, ct_lvl);
        end
    endtask

    task automatic test_drop_error();
        soc();
        rx_byte(8'h11, 3'd0);
        rx_byte(8'h22, 3'd0);
        rx_parity_error = 1'b1;
        rx_eoc          = 1'b1;
        cyc();
        rx_parity_error = 1'b0;
        rx_eoc          = 1'b0;
        vec_cnt++;
        if ({sf_drp, sf_ovf, sf_rdy, sf_lvl} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL drop_pulse: got drp=%b ovf=%b rdy=%b lvl=%0d, expected 1 0 0 0",
                     sf_drp, sf_ovf, sf_rdy, sf_lvl);
        end
        cyc();
        vec_cnt++;
        if ({sf_drp, sf_rdy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL drop_one_cycle: got drp=%b rdy=%b, expected 0 0", sf_drp, sf_rdy);
        end
        soc();
        rx_byte(8'h81, 3'd0);
        eoc();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_bits, sf_lvl} !== {1'b1, 8'h81, 3'd0, 5'd1}) begin
            err_cnt++;
            $display("FAIL drop_next_frame: got rdy=%b data=%h bits=%0d lvl=%0d, expected 1 81 0 1",
                     sf_rdy, sf_data, sf_bits, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL drop_next_drain: got rdy=%b lvl=%0d, expected rdy=0 lvl=0", sf_rdy, sf_lvl);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        soc();
        for (int i = 0; i < 4; i++) rx_byte(8'(8'hC0 + i), 3'd0);
        vec_cnt++;
        if ({d4_lvl, d4_ovf, d4_drp} !== {3'd4, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL ovf_full: got lvl=%0d ovf=%b drp=%b, expected 4 0 0", d4_lvl, d4_ovf, d4_drp);
        end
        rx_byte(8'hC4, 3'd0);
        vec_cnt++;
        if ({d4_ovf, d4_drp, d4_lvl, d4_rdy} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL ovf_pulse: got ovf=%b drp=%b lvl=%0d rdy=%b, expected 1 1 0 0",
                     d4_ovf, d4_drp, d4_lvl, d4_rdy);
        end
        rx_byte(8'hC5, 3'd0);
        vec_cnt++;
        if ({d4_ovf, d4_drp, d4_lvl, d4_rdy} !== {1'b0, 1'b0, 3'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL ovf_after: got ovf=%b drp=%b lvl=%0d rdy=%b, expected 0 0 0 0",
                     d4_ovf, d4_drp, d4_lvl, d4_rdy);
        end
        eoc();
        vec_cnt++;
        if ({d4_rdy, d4_lvl} !== {1'b0, 3'd0}) begin
            err_cnt++;
            $display("FAIL ovf_eoc: got rdy=%b lvl=%0d, expected 0 0", d4_rdy, d4_lvl);
        end
    endtask

    task automatic test_partial_drain();
        do_reset();
        soc();
        for (int i = 1; i <= 4; i++) rx_byte(8'(i), 3'd0);
        eoc();
        req();
        req();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_lvl} !== {1'b1, 8'h03, 5'd2}) begin
            err_cnt++;
            $display("FAIL pd_mid: got rdy=%b data=%h lvl=%0d, expected 1 03 2", sf_rdy, sf_data, sf_lvl);
        end
        soc();
        vec_cnt++;
        if ({sf_rdy, sf_lvl, sf_drp} !== {1'b0, 5'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL pd_abort: got rdy=%b lvl=%0d drp=%b, expected 0 0 0", sf_rdy, sf_lvl, sf_drp);
        end
        rx_byte(8'h12, 3'd0);
        rx_byte(8'h34, 3'd0);
        eoc();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_lvl} !== {1'b1, 8'h12, 5'd2}) begin
            err_cnt++;
            $display("FAIL pd_new1: got rdy=%b data=%h lvl=%0d, expected 1 12 2", sf_rdy, sf_data, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_data, sf_lvl} !== {1'b1, 8'h34, 5'd1}) begin
            err_cnt++;
            $display("FAIL pd_new2: got rdy=%b data=%h lvl=%0d, expected 1 34 1", sf_rdy, sf_data, sf_lvl);
        end
        req();
        vec_cnt++;
        if ({sf_rdy, sf_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL pd_empty: got rdy=%b lvl=%0d, expected 0 0", sf_rdy, sf_lvl);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] q[$];
        logic [10:0] e;
        do_reset();
        soc();
        for (int i = 0; i < 20; i++) begin
            e             = {3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            rx_data       = e[7:0];
            rx_data_bits  = e[10:8];
            rx_data_valid = 1'b1;
            tx_req        = (i >= 2);
            cyc();
            if (tx_req) void'(q.pop_front());
            q.push_back(e);
            rx_data_valid = 1'b0;
            tx_req        = 1'b0;
            vec_cnt++;
            if ({ct_rdy, ct_lvl, ct_bits, ct_data} !== {1'b1, 5'(q.size()), q[0]}) begin
                err_cnt++;
                $display("FAIL b2b_%0d: got rdy=%b lvl=%0d bits=%0d data=%h, expected 1 %0d %0d %h",
                         i, ct_rdy, ct_lvl, ct_bits, ct_data, q.size(), q[0][10:8], q[0][7:0]);
            end
        end
        eoc();
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            req();
            void'(q.pop_front());
            vec_cnt++;
            if (q.size() > 0) begin
                if ({ct_rdy, ct_bits, ct_data} !== {1'b1, q[0]}) begin
                    err_cnt++;
                    $display("FAIL b2b_drain_%0d: got rdy=%b bits=%0d data=%h, expected 1 %0d %h",
                             i, ct_rdy, ct_bits, ct_data, q[0][10:8], q[0][7:0]);
                end
            end else if ({ct_rdy, ct_lvl} !== {1'b0, 5'd0}) begin
                err_cnt++;
                $display("FAIL b2b_drain_end: got rdy=%b lvl=%0d, expected 0 0", ct_rdy, ct_lvl);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        soc();
        rx_byte(8'hAA, 3'd3);
        rx_byte(8'hBB, 3'd0);
        vec_cnt++;
        if ({ct_rdy, ct_data, ct_lvl} !== {1'b1, 8'hAA, 5'd2}) begin
            err_cnt++;
            $display("FAIL rst_pre: got rdy=%b data=%h lvl=%0d, expected 1 aa 2", ct_rdy, ct_data, ct_lvl);
        end
        #10;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({ct_data, ct_bits, ct_rdy, ct_lvl, ct_ovf, ct_drp} !== 19'd0) begin
            err_cnt++;
            $display("FAIL rst_async: got data=%h bits=%0d rdy=%b lvl=%0d ovf=%b drp=%b, expected all 0",
                     ct_data, ct_bits, ct_rdy, ct_lvl, ct_ovf, ct_drp);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        rx_byte(8'hCC, 3'd0);
        vec_cnt++;
        if ({ct_rdy, ct_lvl} !== {1'b0, 5'd0}) begin
            err_cnt++;
            $display("FAIL rst_idle_after: got rdy=%b lvl=%0d, expected 0 0", ct_rdy, ct_lvl);
        end
    endtask

    initial begin
        test_reset();
        test_store_forward();
        test_cut_through();
        test_drop_error();
        test_overflow();
        test_partial_drain();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
